// File: rtl/bresenham_3d_stream.sv
// Purpose: streaming 3-axis Bresenham line generator; emits every point (start and end inclusive) with per-axis step/dir flags.
// Latency: i_start sampled at edge N, first point valid after edge N+3; then one point per cycle at full ready.
// Backpressure: valid/ready on the point port; payload held stable while o_pt_valid && !i_pt_ready; no point buffer.
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_x0/i_y0/i_z0, i_x1/...    signed line endpoints, captured when i_start is accepted in IDLE
//   i_start, i_abort            load a new line / abandon the current one (abort wins over start)
//   o_busy                      high whenever a line is being set up or emitted
//   o_pt_x/y/z, o_pt_valid      current point and its valid
//   i_pt_ready, o_pt_last       downstream accept, endpoint marker
//   o_step_en, o_step_dir       {z,y,x} moved-this-point flags and negative-direction flags
module bresenham_3d_stream #(
    parameter int P_COORD_W = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic signed [P_COORD_W-1:0] i_x0,
    input  logic signed [P_COORD_W-1:0] i_y0,
    input  logic signed [P_COORD_W-1:0] i_z0,
    input  logic signed [P_COORD_W-1:0] i_x1,
    input  logic signed [P_COORD_W-1:0] i_y1,
    input  logic signed [P_COORD_W-1:0] i_z1,
    input  logic                        i_start,
    input  logic                        i_abort,
    output logic                        o_busy,
    output logic signed [P_COORD_W-1:0] o_pt_x,
    output logic signed [P_COORD_W-1:0] o_pt_y,
    output logic signed [P_COORD_W-1:0] o_pt_z,
    output logic                        o_pt_valid,
    input  logic                        i_pt_ready,
    output logic                        o_pt_last,
    output logic [2:0]                  o_step_en,
    output logic [2:0]                  o_step_dir
);

    // Deltas need one extra bit so a full-range span cannot overflow;
    // errors hold 2*delta plus a sign bit.
    localparam int DW = P_COORD_W + 1;
    localparam int EW = P_COORD_W + 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_SELECT = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [2:0][P_COORD_W-1:0]     p0_q, p0_d;      // start point, index 0=x 1=y 2=z
    logic [2:0][P_COORD_W-1:0]     p1_q, p1_d;      // end point
    logic [2:0][DW-1:0]            dlt_q, dlt_d;    // |delta| per axis
    logic [2:0]                    dir_q, dir_d;    // 1 = axis moves negative
    logic [2:0]                    maj_q, maj_d;    // one-hot major axis
    logic [DW-1:0]                 dmaj_q, dmaj_d;  // delta of the major axis
    logic [DW-1:0]                 cnt_q, cnt_d;    // points emitted after the start point
    logic [2:0][EW-1:0]            err_q, err_d;    // signed error per axis (major entry unused)
    logic [2:0][P_COORD_W-1:0]     pt_q, pt_d;
    logic                          pt_valid_q, pt_valid_d;
    logic                          pt_last_q, pt_last_d;
    logic [2:0]                    step_en_q, step_en_d;
    logic [2:0]                    step_dir_q, step_dir_d;

    logic [DW-1:0]                 diff;
    logic [DW-1:0]                 dm_sel;
    logic [EW-1:0]                 err_tmp;

    always_comb begin
        state_d    = state_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        dlt_d      = dlt_q;
        dir_d      = dir_q;
        maj_d      = maj_q;
        dmaj_d     = dmaj_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pt_d       = pt_q;
        pt_valid_d = pt_valid_q;
        pt_last_d  = pt_last_q;
        step_en_d  = step_en_q;
        step_dir_d = step_dir_q;
        diff       = '0;
        dm_sel     = '0;
        err_tmp    = '0;

        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    p0_d    = {i_z0, i_y0, i_x0};
                    p1_d    = {i_z1, i_y1, i_x1};
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                for (int k = 0; k < 3; k++) begin
                    // Sign-extend both ends so the subtraction is exact.
                    diff     = {p1_q[k][P_COORD_W-1], p1_q[k]} - {p0_q[k][P_COORD_W-1], p0_q[k]};
                    dir_d[k] = diff[DW-1];
                    dlt_d[k] = diff[DW-1] ? (DW'(0) - diff) : diff;
                end
                state_d = S_SELECT;
            end

            S_SELECT: begin
                // Ties favour x, then y, then z.
                if (dlt_q[0] >= dlt_q[1] && dlt_q[0] >= dlt_q[2]) begin
                    maj_d  = 3'b001;
                    dm_sel = dlt_q[0];
                end else if (dlt_q[1] >= dlt_q[2]) begin
                    maj_d  = 3'b010;
                    dm_sel = dlt_q[1];
                end else begin
                    maj_d  = 3'b100;
                    dm_sel = dlt_q[2];
                end
                dmaj_d = dm_sel;
                for (int k = 0; k < 3; k++) begin
                    err_d[k] = {1'b0, dlt_q[k], 1'b0} - {2'b00, dm_sel};
                end
                cnt_d   = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                if (!pt_valid_q) begin
                    // First RUN cycle: present the start point.
                    pt_valid_d = 1'b1;
                    pt_d       = p0_q;
                    step_en_d  = 3'b000;
                    step_dir_d = dir_q;
                    pt_last_d  = (dmaj_q == '0);
                end else if (i_pt_ready) begin
                    if (pt_last_q) begin
                        state_d    = S_IDLE;
                        pt_valid_d = 1'b0;
                        pt_last_d  = 1'b0;
                        step_en_d  = 3'b000;
                    end else begin
                        cnt_d     = cnt_q + DW'(1);
                        pt_last_d = ((cnt_q + DW'(1)) == dmaj_q);
                        step_en_d = 3'b000;
                        for (int k = 0; k < 3; k++) begin
                            if (maj_q[k]) begin
                                pt_d[k]      = pt_q[k] + (dir_q[k] ? {P_COORD_W{1'b1}} : P_COORD_W'(1));
                                step_en_d[k] = 1'b1;
                            end else begin
                                err_tmp = err_q[k];
                                if (!err_tmp[EW-1]) begin
                                    pt_d[k]      = pt_q[k] + (dir_q[k] ? {P_COORD_W{1'b1}} : P_COORD_W'(1));
                                    step_en_d[k] = 1'b1;
                                    err_tmp      = err_tmp - {1'b0, dmaj_q, 1'b0};
                                end
                                err_d[k] = err_tmp + {1'b0, dlt_q[k], 1'b0};
                            end
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (i_abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            pt_valid_d = 1'b0;
            pt_last_d  = 1'b0;
            step_en_d  = 3'b000;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            p0_q       <= '0;
            p1_q       <= '0;
            dlt_q      <= '0;
            dir_q      <= '0;
            maj_q      <= '0;
            dmaj_q     <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            pt_q       <= '0;
            pt_valid_q <= 1'b0;
            pt_last_q  <= 1'b0;
            step_en_q  <= '0;
            step_dir_q <= '0;
        end else begin
            state_q    <= state_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            dlt_q      <= dlt_d;
            dir_q      <= dir_d;
            maj_q      <= maj_d;
            dmaj_q     <= dmaj_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            pt_q       <= pt_d;
            pt_valid_q <= pt_valid_d;
            pt_last_q  <= pt_last_d;
            step_en_q  <= step_en_d;
            step_dir_q <= step_dir_d;
        end
    end

    assign o_busy     = (state_q != S_IDLE);
    assign o_pt_x     = pt_q[0];
    assign o_pt_y     = pt_q[1];
    assign o_pt_z     = pt_q[2];
    assign o_pt_valid = pt_valid_q;
    assign o_pt_last  = pt_last_q;
    assign o_step_en  = step_en_q;
    assign o_step_dir = step_dir_q;

endmodule

// File: tb/tb_bresenham_3d_stream.sv
// Purpose: self-checking bench for bresenham_3d_stream against an array-based line model.
// Latency: checks the start-to-first-point delay and one-point-per-cycle streaming.
// Backpressure: drives full, toggling and random i_pt_ready and checks payload hold while stalled.
module tb_bresenham_3d_stream;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic         last;
        logic [2:0]   en;
        logic [2:0]   dir;
    } beat_t;

    logic                i_clk = 1'b0;
    logic                i_reset_n;
    logic signed [W-1:0] i_x0, i_y0, i_z0, i_x1, i_y1, i_z1;
    logic                i_start, i_abort, i_pt_ready;
    logic                o_busy, o_pt_valid, o_pt_last;
    logic signed [W-1:0] o_pt_x, o_pt_y, o_pt_z;
    logic [2:0]          o_step_en, o_step_dir;

    int    n_assert = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];

    bresenham_3d_stream #(.P_COORD_W(W)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_x0       (i_x0),
        .i_y0       (i_y0),
        .i_z0       (i_z0),
        .i_x1       (i_x1),
        .i_y1       (i_y1),
        .i_z1       (i_z1),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .o_busy     (o_busy),
        .o_pt_x     (o_pt_x),
        .o_pt_y     (o_pt_y),
        .o_pt_z     (o_pt_z),
        .o_pt_valid (o_pt_valid),
        .i_pt_ready (i_pt_ready),
        .o_pt_last  (o_pt_last),
        .o_step_en  (o_step_en),
        .o_step_dir (o_step_dir)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        beat_t b;
        b.x    = o_pt_x;
        b.y    = o_pt_y;
        b.z    = o_pt_z;
        b.last = o_pt_last;
        b.en   = o_step_en;
        b.dir  = o_step_dir;
        return b;
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({o_busy, o_pt_valid, o_pt_last, o_step_en, o_step_dir, o_pt_x, o_pt_y, o_pt_z});
    endfunction

    task automatic push_exp(input int x, input int y, input int z, input bit last,
                            input logic [2:0] en, input logic [2:0] dir);
        beat_t b;
        b.x = W'(x); b.y = W'(y); b.z = W'(z);
        b.last = last; b.en = en; b.dir = dir;
        exp_q.push_back(b);
    endtask

    // Reference line: walk the major axis one unit per point; each minor axis
    // steps whenever its error term is non-negative.
    task automatic model_line(input int x0, input int y0, input int z0,
                              input int x1, input int y1, input int z1);
        int p[3], q[3], d[3], s[3], e[3];
        int m;
        logic [2:0] dirv, en;
        p[0] = x0; p[1] = y0; p[2] = z0;
        q[0] = x1; q[1] = y1; q[2] = z1;
        for (int k = 0; k < 3; k++) begin
            d[k]    = (q[k] >= p[k]) ? q[k] - p[k] : p[k] - q[k];
            s[k]    = (q[k] < p[k]) ? -1 : 1;
            dirv[k] = (q[k] < p[k]);
        end
        m = 0;
        if (d[1] > d[m]) m = 1;
        if (d[2] > d[m]) m = 2;
        for (int k = 0; k < 3; k++) e[k] = 2 * d[k] - d[m];
        push_exp(p[0], p[1], p[2], d[m] == 0, 3'b000, dirv);
        for (int n = 1; n <= d[m]; n++) begin
            en = 3'b000;
            p[m] += s[m];
            en[m] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (k != m) begin
                    if (e[k] >= 0) begin
                        p[k] += s[k];
                        e[k] -= 2 * d[m];
                        en[k] = 1'b1;
                    end
                    e[k] += 2 * d[k];
                end
            end
            push_exp(p[0], p[1], p[2], n == d[m], en, dirv);
        end
    endtask

    // rmode: 0 = always ready, 1 = ready toggling 1010.., 2 = random ready plus
    // random i_start pulses with junk endpoints while busy.
    task automatic drive_line(input string tag, input int x0, input int y0, input int z0,
                              input int x1, input int y1, input int z1,
                              input int rmode, input bit use_model);
        int    budget, cycles;
        bit    rdy, tog, stalled;
        beat_t held, obs, exp;
        if (use_model) model_line(x0, y0, z0, x1, y1, z1);
        budget = 4 * exp_q.size() + 20;
        @(negedge i_clk);
        i_x0 = W'(x0); i_y0 = W'(y0); i_z0 = W'(z0);
        i_x1 = W'(x1); i_y1 = W'(y1); i_z1 = W'(z1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk({tag, "_lat0"}, 64'({o_busy, o_pt_valid}), 64'b10);
        @(negedge i_clk);
        chk({tag, "_lat1"}, 64'(o_pt_valid), 64'd0);
        @(negedge i_clk);
        chk({tag, "_lat2"}, 64'(o_pt_valid), 64'd0);
        @(negedge i_clk);
        chk({tag, "_lat3"}, 64'(o_pt_valid), 64'd1);
        cycles  = 0;
        stalled = 1'b0;
        tog     = 1'b1;
        held    = '0;
        while (exp_q.size() > 0 && cycles < budget) begin
            case (rmode)
                0:       rdy = 1'b1;
                1: begin rdy = tog; tog = !tog; end
                default: rdy = ($urandom_range(9) < 7);
            endcase
            if (rmode == 2) begin
                i_start = ($urandom_range(3) == 0);
                i_x0 = W'($urandom); i_y0 = W'($urandom); i_z0 = W'($urandom);
                i_x1 = W'($urandom); i_y1 = W'($urandom); i_z1 = W'($urandom);
            end
            i_pt_ready = rdy;
            obs = cur_beat();
            if (stalled) chk({tag, "_hold"}, 64'({o_pt_valid, obs}), 64'({1'b1, held}));
            stalled = 1'b0;
            if (o_pt_valid && rdy) begin
                exp = exp_q.pop_front();
                chk({tag, "_pt"}, 64'(obs), 64'(exp));
            end else if (o_pt_valid) begin
                stalled = 1'b1;
                held    = obs;
            end
            @(negedge i_clk);
            cycles++;
        end
        chk({tag, "_timeout_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        i_start    = 1'b0;
        i_pt_ready = 1'b0;
        chk({tag, "_idle_after"}, 64'({o_pt_valid, o_busy}), 64'd0);
    endtask

    initial begin
        i_reset_n  = 1'b0;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_pt_ready = 1'b0;
        i_x0 = '0; i_y0 = '0; i_z0 = '0;
        i_x1 = '0; i_y1 = '0; i_z1 = '0;
        repeat (2) @(negedge i_clk);
        chk("reset_outputs", all_outputs(), 64'd0);
        i_reset_n = 1'b1;

        // Line (0,0,0)->(5,2,1) against a hand-derived table, full ready.
        push_exp(0, 0, 0, 0, 3'b000, 3'b000);
        push_exp(1, 0, 0, 0, 3'b001, 3'b000);
        push_exp(2, 1, 0, 0, 3'b011, 3'b000);
        push_exp(3, 1, 1, 0, 3'b101, 3'b000);
        push_exp(4, 2, 1, 0, 3'b011, 3'b000);
        push_exp(5, 2, 1, 1, 3'b001, 3'b000);
        drive_line("t1", 0, 0, 0, 5, 2, 1, 0, 1'b0);

        // Negative x, flat y, positive z.
        drive_line("t2", 3, 3, 3, -2, 3, 7, 0, 1'b1);

        // Same line as t1 with toggling ready.
        drive_line("t3", 0, 0, 0, 5, 2, 1, 1, 1'b1);

        // Degenerate single-point line.
        drive_line("t4", 7, -4, 9, 7, -4, 9, 0, 1'b1);

        // Abort on the third point; abort also beats a simultaneous handshake.
        @(negedge i_clk);
        i_x0 = '0; i_y0 = '0; i_z0 = '0;
        i_x1 = W'(5); i_y1 = W'(2); i_z1 = W'(1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start    = 1'b0;
        i_pt_ready = 1'b1;
        repeat (5) @(negedge i_clk);
        chk("abort_pt3", 64'({o_pt_valid, o_pt_x, o_pt_y, o_pt_z}), 64'({1'b1, 16'sd2, 16'sd1, 16'sd0}));
        i_abort = 1'b1;
        @(negedge i_clk);
        chk("abort_drop", 64'({o_pt_valid, o_busy}), 64'd0);
        i_start = 1'b1;
        @(negedge i_clk);
        chk("abort_beats_start", 64'(o_busy), 64'd0);
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_pt_ready = 1'b0;
        drive_line("after_abort", -1, 2, -3, 4, -6, 8, 0, 1'b1);

        // Asynchronous reset in the middle of a line.
        @(negedge i_clk);
        i_x0 = '0; i_y0 = '0; i_z0 = '0;
        i_x1 = W'(5); i_y1 = W'(2); i_z1 = W'(1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start    = 1'b0;
        i_pt_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("pre_reset_busy", 64'({o_busy, o_pt_valid}), 64'b11);
        i_reset_n = 1'b0;
        #1;
        chk("reset_midline", all_outputs(), 64'd0);
        @(negedge i_clk);
        i_reset_n  = 1'b1;
        i_pt_ready = 1'b0;
        drive_line("after_reset", 5, 2, 1, 0, 0, 0, 2, 1'b1);

        // Random short lines with random backpressure and ignored restarts.
        for (int r = 0; r < 20; r++) begin
            drive_line("rand",
                       int'($urandom_range(80)) - 40, int'($urandom_range(80)) - 40,
                       int'($urandom_range(80)) - 40, int'($urandom_range(80)) - 40,
                       int'($urandom_range(80)) - 40, int'($urandom_range(80)) - 40,
                       2, 1'b1);
        end

        // Full-range x span: no overflow, exact final point.
        drive_line("t5_span", -32767, 0, 0, 32767, 0, 0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
